// File: rtl/div_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl_pkg
//   Shared definitions for the execute-stage DIV/DIVU sequencer:
//   - default operand width
//   - FSM state encodings (DIV_IDLE / DIV_CALC / DIV_DONE)
//   - sign-fixup helpers applied to the unsigned magnitude result
// ---------------------------------------------------------------------------
package div_seq_ctrl_pkg;

    // Operand/result width used when a parent does not override it.
    localparam int DIV_WIDTH_DEFAULT = 32;

    // Sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

    // The quotient of a signed divide is negative when the operand signs differ.
    function automatic logic quoNegate(input logic isSigned, input logic signA, input logic signB);
        return isSigned & (signA ^ signB);
    endfunction

    // The remainder takes the sign of the dividend.
    function automatic logic remNegate(input logic isSigned, input logic signA);
        return isSigned & signA;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl_if
//   E-stage handshake between the pipeline and the divide sequencer.
//   master : pipeline side (drives start/operands/flush/stall, sees results)
//   slave  : divider side
//   Signals:
//     div_startE  DIV/DIVU valid in E        signed_divE  1 = DIV, 0 = DIVU
//     opaE        dividend (rs)              opbE         divisor (rt)
//     flushE      E-stage flush              stallE       stall from other sources
//     div_stallE  freeze F/D/E while busy    div_readyE   result valid this cycle
//     div_hiE     remainder                  div_loE      quotient
// ---------------------------------------------------------------------------
interface div_seq_ctrl_if
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             div_startE;
    logic             signed_divE;
    logic [WIDTH-1:0] opaE;
    logic [WIDTH-1:0] opbE;
    logic             flushE;
    logic             stallE;
    logic             div_stallE;
    logic             div_readyE;
    logic [WIDTH-1:0] div_hiE;
    logic [WIDTH-1:0] div_loE;

    modport master (
        output div_startE, signed_divE, opaE, opbE, flushE, stallE,
        input  div_stallE, div_readyE, div_hiE, div_loE
    );

    modport slave (
        input  div_startE, signed_divE, opaE, opbE, flushE, stallE,
        output div_stallE, div_readyE, div_hiE, div_loE
    );
endinterface

// File: rtl/div_seq_ctrl_step.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl_step
//   One combinational radix-2 restoring divide step, MSB first.
//   i_rem     partial remainder so far
//   i_quo     remaining dividend bits (top) / quotient bits developed (bottom)
//   i_divisor divisor magnitude
//   o_rem     partial remainder after this step
//   o_quo     i_quo shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_seq_ctrl_step
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // Bring the next dividend bit into the remainder; one extra bit of headroom
    // so the trial subtraction's borrow shows up in the MSB.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    // Borrow set means the divisor did not fit: restore (keep the shifted value).
    assign o_rem = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//   Sequencing controller and iterative datapath for DIV/DIVU in the execute
//   stage. Runs a radix-2 restoring divide over WIDTH cycles on operand
//   magnitudes, holds the front of the pipeline via div_stallE meanwhile, then
//   presents a sign-corrected quotient (div_loE) and remainder (div_hiE) with
//   div_readyE for the HI/LO write.
//   Ports:
//     clk   pipeline clock, rising edge
//     rst   asynchronous reset, active low (0 = reset)
//     bus   div_seq_ctrl_if.slave (start/operands/flush/stall in, results out)
//   Build option:
//     DIV_ZERO_FAST_EN  when defined, a zero divisor skips CALC and goes
//                       straight to DONE (ready one cycle after start).
// ---------------------------------------------------------------------------
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    div_seq_ctrl_if.slave  bus
);
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    divState_t        r_state;
    divState_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dividendOrig;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_signA;
    logic             r_signB;
    logic             r_signed;

    logic             w_accept;
    logic             w_lastStep;
    logic             w_stall;
    logic             w_ready;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH-1:0] w_stepRem;
    logic [WIDTH-1:0] w_stepQuo;
    logic [WIDTH-1:0] w_hiFinal;
    logic [WIDTH-1:0] w_loFinal;

    // Magnitudes are only taken for DIV; the most negative value maps onto
    // itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign w_absA = (bus.signed_divE && bus.opaE[WIDTH-1]) ? -bus.opaE : bus.opaE;
    assign w_absB = (bus.signed_divE && bus.opbE[WIDTH-1]) ? -bus.opbE : bus.opbE;

    div_seq_ctrl_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_quo     (w_stepQuo)
    );

    // Final result from the last step: divide-by-zero returns all ones and the
    // original dividend regardless of signedness; otherwise apply sign fixup.
    always_comb begin
        w_hiFinal = w_stepRem;
        w_loFinal = w_stepQuo;
        if (r_divisor == '0) begin
            w_hiFinal = r_dividendOrig;
            w_loFinal = '1;
        end else begin
            if (remNegate(r_signed, r_signA)) begin
                w_hiFinal = -w_stepRem;
            end
            if (quoNegate(r_signed, r_signA, r_signB)) begin
                w_loFinal = -w_stepQuo;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs. A flush always wins and returns to
    // IDLE; stall is raised combinationally in the accepting cycle so the
    // pipeline freezes with the divide still sitting in E.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_lastStep  = 1'b0;
        w_stall     = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (bus.div_startE && !bus.flushE) begin
                    w_accept    = 1'b1;
                    w_stall     = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    w_stateNext = (bus.opbE == '0) ? DIV_DONE : DIV_CALC;
`else
                    w_stateNext = DIV_CALC;
`endif
                end
            end
            DIV_CALC: begin
                w_stall = 1'b1;
                if (bus.flushE) begin
                    w_stateNext = DIV_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_lastStep  = 1'b1;
                    w_stateNext = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_ready = !bus.flushE;
                if (bus.flushE || !bus.stallE) begin
                    w_stateNext = DIV_IDLE;
                end
            end
            default: begin
                w_stateNext = DIV_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, and register the
    // corrected result only when the last step completes (or immediately for
    // a fast zero divisor). Results otherwise hold until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_divisor      <= '0;
            r_dividendOrig <= '0;
            r_hi           <= '0;
            r_lo           <= '0;
            r_signA        <= 1'b0;
            r_signB        <= 1'b0;
            r_signed       <= 1'b0;
        end else if (w_accept) begin
            r_cnt          <= '0;
            r_rem          <= '0;
            r_quo          <= w_absA;
            r_divisor      <= w_absB;
            r_dividendOrig <= bus.opaE;
            r_signA        <= bus.opaE[WIDTH-1];
            r_signB        <= bus.opbE[WIDTH-1];
            r_signed       <= bus.signed_divE;
`ifdef DIV_ZERO_FAST_EN
            if (bus.opbE == '0) begin
                r_hi <= bus.opaE;
                r_lo <= '1;
            end
`endif
        end else if (r_state == DIV_CALC && !bus.flushE) begin
            r_rem <= w_stepRem;
            r_quo <= w_stepQuo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_lastStep) begin
                r_hi <= w_hiFinal;
                r_lo <= w_loFinal;
            end
        end
    end

    assign bus.div_stallE = w_stall;
    assign bus.div_readyE = w_ready;
    assign bus.div_hiE    = r_hi;
    assign bus.div_loE    = r_lo;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Self-checking bench for div_seq_ctrl. Directed cases from the divider's
//   behaviour list plus randomized divides, compared against an arithmetic
//   reference model (integer / and %).
// ---------------------------------------------------------------------------
module tb_div_seq_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;
    logic [31:0] prevHi;
    logic [31:0] prevLo;

    div_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    div_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] refDivide(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Issue one divide, measure stall/ready timing, check the result, then
    // optionally hold DONE with stallE for holdCycles cycles.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input int holdCycles, input string tag);
        logic [63:0] expVal;
        int expLat;
        int lat;
        int stallCnt;
        expVal = refDivide(a, b, sgn);
        expLat = WIDTH + 1;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) expLat = 1;
`endif
        @(negedge clk);
        bus.div_startE  = 1'b1;
        bus.signed_divE = sgn;
        bus.opaE        = a;
        bus.opbE        = b;
        bus.stallE      = 1'($urandom_range(0, 1));
        #1;
        checkOutput({tag, "/stallAtStart"}, {31'd0, bus.div_stallE}, 32'd1);
        lat      = 0;
        stallCnt = 0;
        while (bus.div_readyE !== 1'b1 && lat < 100) begin
            if (bus.div_stallE === 1'b1) stallCnt++;
            @(negedge clk);
            bus.div_startE  = 1'b0;
            bus.opaE        = $urandom;
            bus.opbE        = $urandom;
            bus.signed_divE = 1'($urandom_range(0, 1));
            bus.stallE      = 1'($urandom_range(0, 1));
            #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, lat, expLat);
        checkOutput({tag, "/stallCycles"}, stallCnt, expLat);
        checkOutput({tag, "/stallAtDone"}, {31'd0, bus.div_stallE}, 32'd0);
        checkOutput({tag, "/hi"}, bus.div_hiE, expVal[63:32]);
        checkOutput({tag, "/lo"}, bus.div_loE, expVal[31:0]);
        for (int h = 0; h < holdCycles; h++) begin
            bus.stallE = 1'b1;
            @(negedge clk);
            #1;
            checkOutput({tag, "/readyHeld"}, {31'd0, bus.div_readyE}, 32'd1);
            checkOutput({tag, "/hiHeld"}, bus.div_hiE, expVal[63:32]);
            checkOutput({tag, "/loHeld"}, bus.div_loE, expVal[31:0]);
        end
        bus.stallE = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({tag, "/readyDropped"}, {31'd0, bus.div_readyE}, 32'd0);
        checkOutput({tag, "/hiKeptIdle"}, bus.div_hiE, expVal[63:32]);
        checkOutput({tag, "/loKeptIdle"}, bus.div_loE, expVal[31:0]);
        prevHi = expVal[63:32];
        prevLo = expVal[31:0];
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        checkCount      = 0;
        errorCount      = 0;
        prevHi          = '0;
        prevLo          = '0;
        rst             = 1'b0;
        bus.div_startE  = 1'b0;
        bus.signed_divE = 1'b0;
        bus.opaE        = '0;
        bus.opbE        = '0;
        bus.flushE      = 1'b0;
        bus.stallE      = 1'b0;
        #3;
        checkOutput("reset/stall", {31'd0, bus.div_stallE}, 32'd0);
        checkOutput("reset/ready", {31'd0, bus.div_readyE}, 32'd0);
        checkOutput("reset/hi", bus.div_hiE, 32'd0);
        checkOutput("reset/lo", bus.div_loE, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases.
        applyStimulus(32'd100, 32'd7, 1'b0, 0, "divu100by7");
        applyStimulus(-32'sd7, 32'd2, 1'b1, 0, "divNeg7by2");
        applyStimulus(32'd7, -32'sd2, 1'b1, 0, "div7byNeg2");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "divOverflow");
        applyStimulus(32'd5, 32'd0, 1'b0, 0, "divu5by0");
        applyStimulus(-32'sd5, 32'd0, 1'b1, 0, "divNeg5by0");
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 3, "divuHold3");

        // Flush at T+10 cancels; outputs keep the previous result.
        @(negedge clk);
        bus.div_startE  = 1'b1;
        bus.signed_divE = 1'b0;
        bus.opaE        = 32'd1000;
        bus.opbE        = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.div_startE = 1'b0;
            bus.flushE     = (c == 10);
            #1;
            checkOutput("flush/noReady", {31'd0, bus.div_readyE}, 32'd0);
        end
        @(negedge clk);
        bus.flushE = 1'b0;
        #1;
        checkOutput("flush/idleStall", {31'd0, bus.div_stallE}, 32'd0);
        checkOutput("flush/hiKept", bus.div_hiE, prevHi);
        checkOutput("flush/loKept", bus.div_loE, prevLo);
        applyStimulus(32'd1000, 32'd3, 1'b0, 0, "afterFlush");

        // Flush beats a simultaneous start.
        @(negedge clk);
        bus.div_startE = 1'b1;
        bus.flushE     = 1'b1;
        bus.opaE       = 32'd9;
        bus.opbE       = 32'd4;
        #1;
        checkOutput("flushStart/stall", {31'd0, bus.div_stallE}, 32'd0);
        @(negedge clk);
        bus.div_startE = 1'b0;
        bus.flushE     = 1'b0;
        #1;
        checkOutput("flushStart/notBusy", {31'd0, bus.div_stallE}, 32'd0);

        // Reset in the middle of CALC clears everything at once.
        @(negedge clk);
        bus.div_startE = 1'b1;
        bus.opaE       = 32'd12345;
        bus.opbE       = 32'd17;
        repeat (5) begin
            @(negedge clk);
            bus.div_startE = 1'b0;
        end
        rst = 1'b0;
        #1;
        checkOutput("midReset/stall", {31'd0, bus.div_stallE}, 32'd0);
        checkOutput("midReset/ready", {31'd0, bus.div_readyE}, 32'd0);
        checkOutput("midReset/hi", bus.div_hiE, 32'd0);
        checkOutput("midReset/lo", bus.div_loE, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(32'd12345, 32'd17, 1'b0, 0, "afterReset");

        // Randomized divides.
        for (int i = 0; i < 14; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0 - 32'($urandom_range(1, 15));
                default: rb = (i % 5 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
